axis_pcie_tlp_chan_mux: RTL and testbench

AXIS_PCIE_TLP_CHAN_MUX -- requirements
Module: axis_pcie_tlp_chan_mux

---
 rtl/axis_pcie_tlp_chan_mux.sv | 174 +++++++++++++++++
 tb/tb_axis_pcie_tlp_chan_mux.sv | 361 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axis_pcie_tlp_chan_mux.sv
// Merges several AFU->host TLP beat streams onto one registered output stream.
// Packets stay whole on the output; arbitration between packets is round-robin.
module axis_pcie_tlp_chan_mux #(
  parameter int NUM_CHANNELS  = 2,
  parameter int PAYLOAD_WIDTH = 256,
  parameter int HDR_WIDTH     = 128,
  parameter int IRQ_ID_WIDTH  = 8,
  localparam int CHAN_WIDTH   = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1
) (
  input  logic                                  clk,
  input  logic                                  rst_n,

  input  logic [NUM_CHANNELS-1:0]               in_tvalid,
  output logic [NUM_CHANNELS-1:0]               in_tready,
  input  logic [NUM_CHANNELS*HDR_WIDTH-1:0]     in_hdr,
  input  logic [NUM_CHANNELS*PAYLOAD_WIDTH-1:0] in_payload,
  input  logic [NUM_CHANNELS-1:0]               in_sop,
  input  logic [NUM_CHANNELS-1:0]               in_eop,
  input  logic [NUM_CHANNELS-1:0]               in_afu_irq,
  input  logic [NUM_CHANNELS*IRQ_ID_WIDTH-1:0]  in_irq_id,

  output logic                                  out_tvalid,
  input  logic                                  out_tready,
  output logic [HDR_WIDTH-1:0]                  out_hdr,
  output logic [PAYLOAD_WIDTH-1:0]              out_payload,
  output logic                                  out_sop,
  output logic                                  out_eop,
  output logic                                  out_afu_irq,
  output logic [IRQ_ID_WIDTH-1:0]               out_irq_id,
  output logic [CHAN_WIDTH-1:0]                 out_chan,

  output logic                                  proto_err
);

  localparam logic [CHAN_WIDTH-1:0] LAST_CHAN = CHAN_WIDTH'(NUM_CHANNELS - 1);

  typedef enum logic {
    ARB  = 1'b0,
    LOCK = 1'b1
  } state_t;

  state_t                  state_q, state_d;
  logic [CHAN_WIDTH-1:0]   lock_chan_q, lock_chan_d;
  logic [CHAN_WIDTH-1:0]   last_grant_q, last_grant_d;
  logic                    proto_err_d;

  logic                    ld;
  logic                    xfer;
  logic [CHAN_WIDTH-1:0]   sel;
  logic                    sel_valid;
  int                      rr_idx;

  logic [HDR_WIDTH-1:0]     sel_hdr;
  logic [PAYLOAD_WIDTH-1:0] sel_payload;
  logic                     sel_sop;
  logic                     sel_eop;
  logic                     sel_irq;
  logic [IRQ_ID_WIDTH-1:0]  sel_irq_id;

  // The output register may take a new beat when empty or being drained.
  assign ld   = !out_tvalid || out_tready;
  assign xfer = ld && sel_valid;

  // Open packet pins the grant; otherwise search round-robin after last_grant.
  always_comb begin
    sel       = lock_chan_q;
    sel_valid = 1'b0;
    rr_idx    = 0;
    if (state_q == LOCK) begin
      sel_valid = in_tvalid[lock_chan_q];
    end else begin
      for (int i = 0; i < NUM_CHANNELS; i++) begin
        rr_idx = int'(last_grant_q) + 1 + i;
        if (rr_idx >= NUM_CHANNELS) rr_idx = rr_idx - NUM_CHANNELS;
        if (!sel_valid && in_tvalid[CHAN_WIDTH'(rr_idx)]) begin
          sel       = CHAN_WIDTH'(rr_idx);
          sel_valid = 1'b1;
        end
      end
    end
  end

  always_comb begin
    sel_hdr     = '0;
    sel_payload = '0;
    sel_sop     = 1'b0;
    sel_eop     = 1'b0;
    sel_irq     = 1'b0;
    sel_irq_id  = '0;
    for (int c = 0; c < NUM_CHANNELS; c++) begin
      if (CHAN_WIDTH'(c) == sel) begin
        sel_hdr     = in_hdr[c*HDR_WIDTH +: HDR_WIDTH];
        sel_payload = in_payload[c*PAYLOAD_WIDTH +: PAYLOAD_WIDTH];
        sel_sop     = in_sop[c];
        sel_eop     = in_eop[c];
        sel_irq     = in_afu_irq[c];
        sel_irq_id  = in_irq_id[c*IRQ_ID_WIDTH +: IRQ_ID_WIDTH];
      end
    end
  end

  // Ready is gated by rst_n so nothing is offered while reset is asserted.
  always_comb begin
    in_tready = '0;
    if (rst_n && xfer) in_tready[sel] = 1'b1;
  end

  always_comb begin
    state_d      = state_q;
    lock_chan_d  = lock_chan_q;
    last_grant_d = last_grant_q;
    proto_err_d  = proto_err;
    if (xfer) begin
      if (sel_sop) last_grant_d = sel;
      case (state_q)
        ARB: begin
          if (!sel_sop) begin
            proto_err_d = 1'b1;
          end else if (!sel_eop) begin
            state_d     = LOCK;
            lock_chan_d = sel;
          end
        end
        LOCK: begin
          if (sel_sop) proto_err_d = 1'b1;
          if (sel_eop) state_d = ARB;
        end
        default: state_d = ARB;
      endcase
      // Interrupt messages must be carried in a single beat.
      if (sel_irq && !(sel_sop && sel_eop)) proto_err_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ARB;
      lock_chan_q  <= '0;
      last_grant_q <= LAST_CHAN;
      proto_err    <= 1'b0;
    end else begin
      state_q      <= state_d;
      lock_chan_q  <= lock_chan_d;
      last_grant_q <= last_grant_d;
      proto_err    <= proto_err_d;
    end
  end

  // Output stage: data only moves on a load, so a stalled beat holds still.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_tvalid  <= 1'b0;
      out_hdr     <= '0;
      out_payload <= '0;
      out_sop     <= 1'b0;
      out_eop     <= 1'b0;
      out_afu_irq <= 1'b0;
      out_irq_id  <= '0;
      out_chan    <= '0;
    end else if (ld) begin
      out_tvalid <= sel_valid;
      if (sel_valid) begin
        out_hdr     <= sel_hdr;
        out_payload <= sel_payload;
        out_sop     <= sel_sop;
        out_eop     <= sel_eop;
        out_afu_irq <= sel_irq;
        out_irq_id  <= sel_irq_id;
        out_chan    <= sel;
      end
    end
  end

endmodule

// File: tb/tb_axis_pcie_tlp_chan_mux.sv
// Randomised and directed bench for axis_pcie_tlp_chan_mux against a packet-level
// reference model held in per-channel beat queues.
module tb_axis_pcie_tlp_chan_mux;

  localparam int N  = 3;
  localparam int HW = 32;
  localparam int PW = 64;
  localparam int IW = 8;
  localparam int CW = 2;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic [N-1:0]    in_tvalid, in_tready, in_sop, in_eop, in_afu_irq;
  logic [N*HW-1:0] in_hdr;
  logic [N*PW-1:0] in_payload;
  logic [N*IW-1:0] in_irq_id;
  logic            out_tvalid, out_tready, out_sop, out_eop, out_afu_irq, proto_err;
  logic [HW-1:0]   out_hdr;
  logic [PW-1:0]   out_payload;
  logic [IW-1:0]   out_irq_id;
  logic [CW-1:0]   out_chan;

  axis_pcie_tlp_chan_mux #(
    .NUM_CHANNELS(N), .PAYLOAD_WIDTH(PW), .HDR_WIDTH(HW), .IRQ_ID_WIDTH(IW)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .in_tvalid(in_tvalid), .in_tready(in_tready), .in_hdr(in_hdr), .in_payload(in_payload),
    .in_sop(in_sop), .in_eop(in_eop), .in_afu_irq(in_afu_irq), .in_irq_id(in_irq_id),
    .out_tvalid(out_tvalid), .out_tready(out_tready), .out_hdr(out_hdr),
    .out_payload(out_payload), .out_sop(out_sop), .out_eop(out_eop),
    .out_afu_irq(out_afu_irq), .out_irq_id(out_irq_id), .out_chan(out_chan),
    .proto_err(proto_err)
  );

  typedef struct {
    logic [HW-1:0] hdr;
    logic [PW-1:0] pay;
    logic          sop;
    logic          eop;
    logic          irq;
    logic [IW-1:0] id;
  } beat_t;

  beat_t chq [N][$];
  bit    present [N];
  int    ready_mode;
  int    gap_pct;

  bit    m_valid, m_err;
  beat_t m_beat;
  int    m_chan, m_open, m_last;

  int n_cmp, n_err, cyc;
  int            log_chan [$];
  int            log_cyc  [$];
  logic [PW-1:0] log_pay  [$];
  logic [PW-1:0] pays     [$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("[TB] FAIL %s: actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push_beat(input int c, input bit sop, input bit eop, input bit irq,
                           input logic [IW-1:0] id);
    beat_t x;
    x.hdr = $urandom; x.pay = {$urandom, $urandom};
    x.sop = sop; x.eop = eop; x.irq = irq; x.id = id;
    chq[c].push_back(x);
  endtask

  task automatic push_pkt(input int c, input int len);
    for (int b = 0; b < len; b++) begin
      push_beat(c, b == 0, b == len - 1, 1'b0, '0);
      pays.push_back(chq[c][chq[c].size()-1].pay);
    end
  endtask

  task automatic push_rand(input int c, input bit corrupt);
    beat_t pk [4];
    int len, k;
    bit irq;
    logic [IW-1:0] id;
    irq = ($urandom_range(7, 0) == 0);
    len = irq ? 1 : int'($urandom_range(4, 1));
    id  = IW'($urandom);
    for (int b = 0; b < len; b++) begin
      pk[b].hdr = $urandom; pk[b].pay = {$urandom, $urandom};
      pk[b].sop = (b == 0); pk[b].eop = (b == len - 1);
      pk[b].irq = irq; pk[b].id = id;
    end
    if (corrupt && $urandom_range(9, 0) == 0) begin
      k = int'($urandom_range(len - 1, 0));
      case ($urandom_range(2, 0))
        0: pk[k].sop = ~pk[k].sop;
        1: pk[k].eop = ~pk[k].eop;
        default: pk[k].irq = 1'b1;
      endcase
    end
    for (int b = 0; b < len; b++) chq[c].push_back(pk[b]);
  endtask

  task automatic applyStimulus();
    for (int c = 0; c < N; c++) begin
      if (!present[c] && chq[c].size() > 0 && int'($urandom_range(99, 0)) >= gap_pct)
        present[c] = 1'b1;
      in_tvalid[c] = present[c];
      if (present[c]) begin
        in_hdr[c*HW +: HW]    = chq[c][0].hdr;
        in_payload[c*PW +: PW] = chq[c][0].pay;
        in_sop[c]             = chq[c][0].sop;
        in_eop[c]             = chq[c][0].eop;
        in_afu_irq[c]         = chq[c][0].irq;
        in_irq_id[c*IW +: IW] = chq[c][0].id;
      end else begin
        in_hdr[c*HW +: HW]    = $urandom;
        in_payload[c*PW +: PW] = {$urandom, $urandom};
        in_sop[c]             = 1'($urandom);
        in_eop[c]             = 1'($urandom);
        in_afu_irq[c]         = 1'($urandom);
        in_irq_id[c*IW +: IW] = IW'($urandom);
      end
    end
    case (ready_mode)
      0:       out_tready = 1'b1;
      1:       out_tready = ($urandom_range(3, 0) != 0);
      default: out_tready = 1'b0;
    endcase
  endtask

  task automatic checkOutput();
    check("out_tvalid", 64'(out_tvalid), 64'(m_valid));
    check("proto_err", 64'(proto_err), 64'(m_err));
    if (m_valid) begin
      check("out_chan", 64'(out_chan), 64'(m_chan));
      check("out_hdr", 64'(out_hdr), 64'(m_beat.hdr));
      check("out_payload", out_payload, m_beat.pay);
      check("out_sop", 64'(out_sop), 64'(m_beat.sop));
      check("out_eop", 64'(out_eop), 64'(m_beat.eop));
      check("out_afu_irq", 64'(out_afu_irq), 64'(m_beat.irq));
      check("out_irq_id", 64'(out_irq_id), 64'(m_beat.id));
    end
  endtask

  // Packet-level reference: whole packets win round-robin, then own the output.
  task automatic model_step();
    bit ld;
    int g, c;
    logic [N-1:0] exp_rdy;
    beat_t b;
    ld = !m_valid || out_tready;
    g  = -1;
    if (m_open >= 0) begin
      if (present[m_open]) g = m_open;
    end else begin
      for (int i = 1; i <= N; i++) begin
        c = (m_last + i) % N;
        if (g < 0 && present[c]) g = c;
      end
    end
    exp_rdy = (ld && g >= 0) ? (N'(1) << g) : '0;
    check("in_tready", 64'(in_tready), 64'(exp_rdy));
    if (ld) begin
      if (g >= 0) begin
        b = chq[g].pop_front();
        present[g] = 1'b0;
        if ((m_open < 0 && !b.sop) || (m_open >= 0 && b.sop) || (b.irq && !(b.sop && b.eop)))
          m_err = 1'b1;
        if (b.sop) m_last = g;
        if (m_open < 0) begin
          if (b.sop && !b.eop) m_open = g;
        end else if (b.eop) begin
          m_open = -1;
        end
        m_valid = 1'b1;
        m_beat  = b;
        m_chan  = g;
      end else begin
        m_valid = 1'b0;
      end
    end
  endtask

  task automatic run_cycle();
    @(negedge clk);
    cyc++;
    checkOutput();
    applyStimulus();
    #1;
    if (out_tvalid && out_tready) begin
      log_chan.push_back(int'(out_chan));
      log_cyc.push_back(cyc);
      log_pay.push_back(out_payload);
    end
    model_step();
  endtask

  function automatic bit busy();
    busy = m_valid;
    for (int c = 0; c < N; c++) if (chq[c].size() > 0) busy = 1'b1;
  endfunction

  task automatic run_until_idle(input int budget);
    int k = 0;
    while (busy() && k < budget) begin
      run_cycle();
      k++;
    end
    check("drain_timeout", 64'(busy()), 64'(0));
  endtask

  task automatic clear_logs();
    log_chan.delete(); log_cyc.delete(); log_pay.delete(); pays.delete();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    for (int c = 0; c < N; c++) begin
      chq[c].delete();
      present[c] = 1'b0;
    end
    in_tvalid  = '1;
    out_tready = 1'b1;
    m_valid = 1'b0; m_err = 1'b0; m_open = -1; m_last = N - 1;
    #1;
    check("rst_out_tvalid", 64'(out_tvalid), 64'(0));
    check("rst_in_tready", 64'(in_tready), 64'(0));
    check("rst_proto_err", 64'(proto_err), 64'(0));
    check("rst_out_chan", 64'(out_chan), 64'(0));
    check("rst_out_payload", out_payload, 64'(0));
    check("rst_out_hdr", 64'(out_hdr), 64'(0));
    repeat (2) @(negedge clk);
    in_tvalid = '0;
    rst_n = 1'b1;
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    n_cmp = 0; n_err = 0; cyc = 0;
    ready_mode = 0; gap_pct = 0;
    in_tvalid = '0; in_sop = '0; in_eop = '0; in_afu_irq = '0;
    in_hdr = '0; in_payload = '0; in_irq_id = '0; out_tready = 1'b1;
    rst_n = 1'b1;
    #2;
    do_reset();

    // Two channels of single-beat packets alternate every cycle.
    clear_logs();
    for (int i = 0; i < 4; i++) begin
      push_pkt(0, 1);
      push_pkt(1, 1);
    end
    run_until_idle(50);
    check("alt_count", 64'(log_chan.size()), 64'(8));
    for (int i = 0; i < log_chan.size() && i < 8; i++) begin
      check("alt_chan", 64'(log_chan[i]), 64'(i % 2));
      check("alt_cycle", 64'(log_cyc[i]), 64'(log_cyc[0] + i));
    end

    // A 4-beat packet on ch0 is not interleaved by ch1 arriving mid-packet.
    clear_logs();
    push_pkt(0, 4);
    run_cycle();
    push_pkt(1, 1);
    run_until_idle(50);
    check("lock_count", 64'(log_chan.size()), 64'(5));
    for (int i = 0; i < log_chan.size() && i < 5; i++)
      check("lock_chan", 64'(log_chan[i]), 64'((i < 4) ? 0 : 1));

    // Three stall cycles mid-packet: output holds, no ready, nothing lost.
    clear_logs();
    push_pkt(0, 4);
    run_cycle();
    run_cycle();
    ready_mode = 2;
    for (int i = 0; i < 3; i++) begin
      run_cycle();
      check("stall_in_tready", 64'(in_tready), 64'(0));
      check("stall_out_tvalid", 64'(out_tvalid), 64'(1));
      check("stall_payload", out_payload, pays[1]);
    end
    ready_mode = 0;
    run_until_idle(50);
    check("stall_count", 64'(log_pay.size()), 64'(4));
    for (int i = 0; i < log_pay.size() && i < 4; i++)
      check("stall_order", log_pay[i], pays[i]);

    // Single-beat interrupt passes through without a protocol error.
    push_beat(0, 1'b1, 1'b1, 1'b1, 8'h05);
    run_cycle();
    run_cycle();
    check("irq_out_tvalid", 64'(out_tvalid), 64'(1));
    check("irq_flag", 64'(out_afu_irq), 64'(1));
    check("irq_id", 64'(out_irq_id), 64'(8'h05));
    check("irq_proto_err", 64'(proto_err), 64'(0));
    run_until_idle(50);

    // A headless beat on ch1 is forwarded and latches proto_err.
    push_beat(1, 1'b0, 1'b1, 1'b0, '0);
    run_cycle();
    check("err_before", 64'(proto_err), 64'(0));
    run_cycle();
    check("err_out_chan", 64'(out_chan), 64'(1));
    check("err_out_sop", 64'(out_sop), 64'(0));
    check("err_set", 64'(proto_err), 64'(1));
    push_pkt(0, 2);
    push_pkt(2, 3);
    run_until_idle(50);
    check("err_sticky", 64'(proto_err), 64'(1));

    // Reset in the middle of a ch1 packet abandons it.
    do_reset();
    push_pkt(1, 4);
    run_cycle();
    run_cycle();
    check("mid_out_tvalid", 64'(out_tvalid), 64'(1));
    check("mid_out_chan", 64'(out_chan), 64'(1));
    do_reset();
    push_pkt(0, 1);
    run_cycle();
    run_cycle();
    check("post_rst_valid", 64'(out_tvalid), 64'(1));
    check("post_rst_chan", 64'(out_chan), 64'(0));
    check("post_rst_sop", 64'(out_sop), 64'(1));
    check("post_rst_err", 64'(proto_err), 64'(0));
    run_until_idle(50);

    // Random well-formed traffic with gaps and backpressure.
    ready_mode = 1; gap_pct = 30;
    for (int t = 0; t < 1500; t++) begin
      for (int c = 0; c < N; c++)
        if (chq[c].size() < 3 && $urandom_range(99, 0) < 20) push_rand(c, 1'b0);
      run_cycle();
    end
    run_until_idle(400);
    check("rand_clean_err", 64'(proto_err), 64'(0));

    // Random traffic with occasional malformed packets.
    do_reset();
    for (int t = 0; t < 800; t++) begin
      for (int c = 0; c < N; c++)
        if (chq[c].size() < 3 && $urandom_range(99, 0) < 20) push_rand(c, 1'b1);
      run_cycle();
    end
    run_until_idle(400);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
